// File: rtl/vga_pkg.sv
// Shared VGA timing constants and pixel types used by the layer sources and the priority mux.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int PLOT_TOP = 112;
    localparam int PLOT_H   = 256;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    localparam rgb888_t BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};

endpackage

// File: rtl/wave_line_ram.sv
// Ping-pong line buffer: two banks of DEPTH x 8, one write port and one registered read port.
module wave_line_ram #(
    parameter int DEPTH = 640,
    parameter int AW    = 10
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic          i_wbank,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic          i_rbank,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [2][DEPTH];

    // Out-of-range reads hold the last word; the renderer masks those columns anyway.
    always_ff @(posedge i_clk) begin
        if (i_we && (i_waddr < AW'(DEPTH)))
            r_mem[i_wbank][i_waddr] <= i_wdata;
        if (i_raddr < AW'(DEPTH))
            o_rdata <= r_mem[i_rbank][i_raddr];
    end

endmodule

// File: rtl/wave_trace_renderer.sv
// Waveform layer: captures a line of samples and draws it as connected vertical segments.
// Define WAVE_FILL_EN to shade the area below the trace at quarter intensity.
module wave_trace_renderer
    import vga_pkg::rgb888_t;
    import vga_pkg::BLACK;
#(
    parameter int      H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int      PLOT_TOP   = vga_pkg::PLOT_TOP,
    parameter rgb888_t WAVE_COLOR = 24'hFFFF00
) (
    input  logic       clock25MHz,
    input  logic       reset,
    input  logic [7:0] sampleIn,
    input  logic       sampleValid,
    input  logic       captureArm,
    input  logic       frameStart,
    input  logic [9:0] xOrd,
    input  logic [9:0] yOrd,
    input  logic       visible,
    output logic       captureBusy,
    output logic       frontValid,
    output logic [7:0] waveR,
    output logic [7:0] waveG,
    output logic [7:0] waveB
);

    localparam int PIPE_LAT = 2;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} cap_state_t;

    cap_state_t r_state, w_next;
    logic [9:0] r_wrAddr;
    logic       r_frontSel;
    logic       r_frontValid;
    logic       w_we, w_swap, w_busy;

    // Capture FSM
    always_ff @(posedge clock25MHz) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (captureArm) w_next = S_FILL;
            S_FILL:  if (sampleValid && (r_wrAddr == 10'(H_ACTIVE - 1))) w_next = S_DONE;
            S_DONE:  if (frameStart) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_we   = (r_state == S_FILL) && sampleValid;
        w_swap = (r_state == S_DONE) && frameStart;
        w_busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clock25MHz) begin
        if (reset) begin
            r_wrAddr     <= '0;
            r_frontSel   <= 1'b0;
            r_frontValid <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && captureArm) r_wrAddr <= '0;
            else if (w_we)                         r_wrAddr <= r_wrAddr + 10'd1;
            if (w_swap) begin
                r_frontSel   <= ~r_frontSel;
                r_frontValid <= 1'b1;
            end
        end
    end

    assign captureBusy = w_busy;
    assign frontValid  = r_frontValid;

    logic [7:0] w_rdata;

    wave_line_ram #(.DEPTH(H_ACTIVE), .AW(10)) u_ram (
        .i_clk   (clock25MHz),
        .i_we    (w_we),
        .i_wbank (~r_frontSel),
        .i_waddr (r_wrAddr),
        .i_wdata (sampleIn),
        .i_rbank (r_frontSel),
        .i_raddr (xOrd),
        .o_rdata (w_rdata)
    );

    // Stage 0 sidebands, aligned with the registered RAM read
    logic [10:0] r_s0_row;
    logic        r_s0_vis, r_s0_x0, r_s0_inx;
    logic [7:0]  r_prev;

    always_ff @(posedge clock25MHz) begin
        if (reset) begin
            r_s0_row <= '0;
            r_s0_vis <= 1'b0;
            r_s0_x0  <= 1'b0;
            r_s0_inx <= 1'b0;
        end else begin
            r_s0_row <= {1'b0, yOrd} - 11'(PLOT_TOP);
            r_s0_vis <= visible;
            r_s0_x0  <= (xOrd == 10'd0);
            r_s0_inx <= (xOrd < 10'(H_ACTIVE));
        end
    end

    // Stage 1: segment between this column's and the previous column's target rows
    logic [7:0] w_cur, w_prev, w_tCur, w_tPrev, w_lo, w_hi, w_row8;
    logic       w_inPlot, w_active, w_lit;
    rgb888_t    w_rgb;

    always_comb begin
        w_cur    = w_rdata;
        w_prev   = r_s0_x0 ? w_rdata : r_prev;
        w_tCur   = 8'd255 - w_cur;
        w_tPrev  = 8'd255 - w_prev;
        w_lo     = (w_tCur < w_tPrev) ? w_tCur : w_tPrev;
        w_hi     = (w_tCur < w_tPrev) ? w_tPrev : w_tCur;
        w_row8   = r_s0_row[7:0];
        w_inPlot = (r_s0_row[10:8] == 3'b000);
        w_active = r_s0_vis && r_frontValid && r_s0_inx && w_inPlot;
        w_lit    = w_active && (w_row8 >= w_lo) && (w_row8 <= w_hi);
        w_rgb    = BLACK;
        if (w_lit)
            w_rgb = WAVE_COLOR;
`ifdef WAVE_FILL_EN
        else if (w_active && (w_row8 > w_hi))
            w_rgb = '{r: WAVE_COLOR.r >> 2, g: WAVE_COLOR.g >> 2, b: WAVE_COLOR.b >> 2};
`endif
    end

    // Stage 2: registered colour, PIPE_LAT cycles after the pixel coordinates
    always_ff @(posedge clock25MHz) begin
        if (reset) begin
            r_prev <= '0;
            waveR  <= '0;
            waveG  <= '0;
            waveB  <= '0;
        end else begin
            r_prev <= w_cur;
            {waveR, waveG, waveB} <= w_rgb;
        end
    end

endmodule

// File: tb/tb_wave_trace_renderer.sv
// Directed self-checking bench for wave_trace_renderer (default and WAVE_FILL_EN builds).
module tb_wave_trace_renderer;

    localparam int PT = 112;

    logic       clock25MHz = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sampleIn = '0;
    logic       sampleValid = 1'b0;
    logic       captureArm = 1'b0;
    logic       frameStart = 1'b0;
    logic [9:0] xOrd = '0;
    logic [9:0] yOrd = '0;
    logic       visible = 1'b0;
    logic       captureBusy, frontValid;
    logic [7:0] waveR, waveG, waveB;

    int checks = 0;
    int fails  = 0;

    wave_trace_renderer dut (
        .clock25MHz (clock25MHz),
        .reset      (reset),
        .sampleIn   (sampleIn),
        .sampleValid(sampleValid),
        .captureArm (captureArm),
        .frameStart (frameStart),
        .xOrd       (xOrd),
        .yOrd       (yOrd),
        .visible    (visible),
        .captureBusy(captureBusy),
        .frontValid (frontValid),
        .waveR      (waveR),
        .waveG      (waveG),
        .waveB      (waveB)
    );

    always #20 clock25MHz = ~clock25MHz;

    // Present column x-1 then x on consecutive cycles so "prev" is the real neighbour,
    // then sample the colour two edges after x was taken.
    task automatic probe(input int x, input int y, input logic vis, output logic [23:0] rgb);
        xOrd = (x == 0) ? 10'd0 : 10'(x - 1);
        yOrd = 10'(y);
        visible = vis;
        @(negedge clock25MHz);
        xOrd = 10'(x);
        @(negedge clock25MHz);
        @(negedge clock25MHz);
        rgb = {waveR, waveG, waveB};
        visible = 1'b0;
    endtask

    // mode 0: constant val, mode 1: ramp x[7:0]. Valid has gaps and a stray arm mid-fill.
    task automatic do_capture(input int mode, input int val, input int n);
        int idx, cyc;
        @(negedge clock25MHz);
        captureArm = 1'b1;
        @(negedge clock25MHz);
        captureArm = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 4000) begin
            sampleValid = (cyc % 7 != 3);
            sampleIn    = (mode == 1) ? 8'(idx) : 8'(val);
            captureArm  = (cyc == 100);
            @(negedge clock25MHz);
            if (sampleValid) idx++;
            cyc++;
        end
        sampleValid = 1'b0;
        captureArm  = 1'b0;
    endtask

    task automatic pulse_frame();
        frameStart = 1'b1;
        @(negedge clock25MHz);
        frameStart = 1'b0;
        @(negedge clock25MHz);
    endtask

    task automatic test_reset();
        visible = 1'b1; xOrd = 10'd5; yOrd = 10'd200;
        for (int i = 0; i < 4; i++) begin
            sampleValid = i[0];
            @(negedge clock25MHz);
        end
        reset = 1'b0;
        checks++; if ({waveR, waveG, waveB} !== 24'h0) begin fails++; $display("FAIL reset_rgb: got %h want 000000", {waveR, waveG, waveB}); end
        checks++; if (frontValid !== 1'b0) begin fails++; $display("FAIL reset_fv: got %b want 0", frontValid); end
        checks++; if (captureBusy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", captureBusy); end
        for (int i = 0; i < 10; i++) begin
            sampleValid = i[0];
            frameStart  = (i == 4);
            @(negedge clock25MHz);
        end
        sampleValid = 1'b0;
        checks++; if ({waveR, waveG, waveB} !== 24'h0) begin fails++; $display("FAIL idle_rgb: got %h want 000000", {waveR, waveG, waveB}); end
        checks++; if (frontValid !== 1'b0) begin fails++; $display("FAIL idle_fv: got %b want 0", frontValid); end
        checks++; if (captureBusy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", captureBusy); end
        visible = 1'b0;
    endtask

    task automatic test_flat();
        logic [23:0] rgb;
        do_capture(0, 128, 640);
        checks++; if (captureBusy !== 1'b1) begin fails++; $display("FAIL flat_done_busy: got %b want 1", captureBusy); end
        pulse_frame();
        checks++; if (frontValid !== 1'b1) begin fails++; $display("FAIL flat_fv: got %b want 1", frontValid); end
        checks++; if (captureBusy !== 1'b0) begin fails++; $display("FAIL flat_busy: got %b want 0", captureBusy); end
        probe(10, PT + 127, 1'b1, rgb);
        checks++; if (rgb !== 24'hFFFF00) begin fails++; $display("FAIL flat_r127: got %h want FFFF00", rgb); end
        probe(10, PT + 126, 1'b1, rgb);
        checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL flat_r126: got %h want 000000", rgb); end
        probe(10, PT + 128, 1'b1, rgb);
        checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL flat_r128: got %h want 000000", rgb); end
        probe(0, PT + 127, 1'b1, rgb);
        checks++; if (rgb !== 24'hFFFF00) begin fails++; $display("FAIL flat_x0: got %h want FFFF00", rgb); end
        probe(639, PT + 127, 1'b1, rgb);
        checks++; if (rgb !== 24'hFFFF00) begin fails++; $display("FAIL flat_x639: got %h want FFFF00", rgb); end
        probe(640, PT + 127, 1'b1, rgb);
        checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL flat_x640: got %h want 000000", rgb); end
        probe(10, PT + 127, 1'b0, rgb);
        checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL flat_invis: got %h want 000000", rgb); end
    endtask

    task automatic test_ramp();
        logic [23:0] rgb;
        int lit;
        do_capture(1, 0, 640);
        pulse_frame();
        lit = 0;
        for (int y = PT; y < PT + 256; y++) begin
            probe(256, y, 1'b1, rgb);
            if (rgb === 24'hFFFF00) lit++;
        end
        checks++; if (lit !== 256) begin fails++; $display("FAIL ramp_c256_count: got %0d want 256", lit); end
        probe(256, PT - 1, 1'b1, rgb);
        checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL ramp_above_plot: got %h want 000000", rgb); end
        probe(256, PT + 256, 1'b1, rgb);
        checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL ramp_below_plot: got %h want 000000", rgb); end
        probe(255, PT + 0, 1'b1, rgb);
        checks++; if (rgb !== 24'hFFFF00) begin fails++; $display("FAIL ramp_c255_r0: got %h want FFFF00", rgb); end
        // column 255 (255) joins column 254 (254): target rows 0 and 1
        probe(255, PT + 1, 1'b1, rgb);
        checks++; if (rgb !== 24'hFFFF00) begin fails++; $display("FAIL ramp_c255_r1: got %h want FFFF00", rgb); end
        probe(255, PT + 2, 1'b1, rgb);
        checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL ramp_c255_r2: got %h want 000000", rgb); end
        probe(100, PT + 155, 1'b1, rgb);
        checks++; if (rgb !== 24'hFFFF00) begin fails++; $display("FAIL ramp_c100_r155: got %h want FFFF00", rgb); end
        probe(100, PT + 154, 1'b1, rgb);
        checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL ramp_c100_r154: got %h want 000000", rgb); end
    endtask

    task automatic test_done_swap();
        logic [23:0] rgb;
        do_capture(0, 128, 640);
        pulse_frame();
        do_capture(0, 60, 640);
        checks++; if (captureBusy !== 1'b1) begin fails++; $display("FAIL swap_pre_busy: got %b want 1", captureBusy); end
        probe(10, PT + 127, 1'b1, rgb);
        checks++; if (rgb !== 24'hFFFF00) begin fails++; $display("FAIL swap_pre_old: got %h want FFFF00", rgb); end
        captureArm = 1'b1;
        frameStart = 1'b1;
        @(negedge clock25MHz);
        captureArm = 1'b0;
        frameStart = 1'b0;
        checks++; if (captureBusy !== 1'b0) begin fails++; $display("FAIL swap_busy: got %b want 0", captureBusy); end
        checks++; if (frontValid !== 1'b1) begin fails++; $display("FAIL swap_fv: got %b want 1", frontValid); end
        for (int i = 0; i < 6; i++) begin
            sampleValid = 1'b1;
            @(negedge clock25MHz);
        end
        sampleValid = 1'b0;
        checks++; if (captureBusy !== 1'b0) begin fails++; $display("FAIL swap_no_rearm: got %b want 0", captureBusy); end
        probe(10, PT + 195, 1'b1, rgb);
        checks++; if (rgb !== 24'hFFFF00) begin fails++; $display("FAIL swap_new: got %h want FFFF00", rgb); end
        probe(10, PT + 127, 1'b1, rgb);
        checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL swap_old_gone: got %h want 000000", rgb); end
    endtask

    task automatic test_reset_abort();
        logic [23:0] rgb;
        do_capture(0, 30, 300);
        checks++; if (captureBusy !== 1'b1) begin fails++; $display("FAIL abort_mid_busy: got %b want 1", captureBusy); end
        reset = 1'b1;
        @(negedge clock25MHz);
        reset = 1'b0;
        checks++; if (captureBusy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", captureBusy); end
        checks++; if (frontValid !== 1'b0) begin fails++; $display("FAIL abort_fv: got %b want 0", frontValid); end
        probe(10, PT + 195, 1'b1, rgb);
        checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL abort_rgb: got %h want 000000", rgb); end
        do_capture(0, 30, 640);
        pulse_frame();
        checks++; if (frontValid !== 1'b1) begin fails++; $display("FAIL abort_re_fv: got %b want 1", frontValid); end
        probe(10, PT + 225, 1'b1, rgb);
        checks++; if (rgb !== 24'hFFFF00) begin fails++; $display("FAIL abort_re_trace: got %h want FFFF00", rgb); end
    endtask

    task automatic test_fill();
        logic [23:0] rgb;
        logic [23:0] below;
`ifdef WAVE_FILL_EN
        below = 24'h3F3F00;
`else
        below = 24'h000000;
`endif
        do_capture(0, 200, 640);
        pulse_frame();
        probe(10, PT + 55, 1'b1, rgb);
        checks++; if (rgb !== 24'hFFFF00) begin fails++; $display("FAIL fill_trace: got %h want FFFF00", rgb); end
        probe(10, PT + 100, 1'b1, rgb);
        checks++; if (rgb !== below) begin fails++; $display("FAIL fill_below: got %h want %h", rgb, below); end
        probe(10, PT + 255, 1'b1, rgb);
        checks++; if (rgb !== below) begin fails++; $display("FAIL fill_bottom: got %h want %h", rgb, below); end
        probe(10, PT + 20, 1'b1, rgb);
        checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL fill_above: got %h want 000000", rgb); end
        probe(10, PT + 256, 1'b1, rgb);
        checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL fill_outside: got %h want 000000", rgb); end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_ramp();
        test_done_swap();
        test_reset_abort();
        test_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
